// File: rtl/fm_bus_master_if.sv
// FM synth bus initiator interface: host request/response handshake plus the synth's parallel bus.
// Latency: none, signal bundle only.
// Backpressure: req_ready from the initiator throttles req_valid; the synth bus itself has none.
//
// Signals:
//   host side : req_valid/req_ready/req_rw/req_addr/req_data in, rsp_valid/rsp_data/busy out
//   synth side: CEb_out/RWb_out/addr_out/data_out/data_oe out, data_in back from the responder
interface fm_bus_master_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [5:0] req_addr;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       CEb_out;
    logic       RWb_out;
    logic [5:0] addr_out;
    logic [7:0] data_out;
    logic       data_oe;
    logic [7:0] data_in;

    // Initiator view.
    modport master (
        input  req_valid, req_rw, req_addr, req_data, data_in,
        output req_ready, rsp_valid, rsp_data, busy,
               CEb_out, RWb_out, addr_out, data_out, data_oe
    );

    // Host plus responder view.
    modport slave (
        output req_valid, req_rw, req_addr, req_data, data_in,
        input  req_ready, rsp_valid, rsp_data, busy,
               CEb_out, RWb_out, addr_out, data_out, data_oe
    );
endinterface

// File: rtl/fm_bus_master.sv
// FM synth bus initiator: queues host register reads/writes and plays them out as CEb/RWb cycles.
// Latency: SETUP visible 1 cycle after accept; a transaction lasts SETUP_CYC+STROBE_CYC+HOLD_CYC cycles.
// Backpressure: req_ready drops while the DEPTH-entry request FIFO is full, whatever the FSM is doing.
//
// Ports:
//   clk, rst : single clock, synchronous active-high reset
//   io_bus   : fm_bus_master_if.master (host request/response, busy, synth parallel bus)
module fm_bus_master #(
    parameter int DEPTH      = 4,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 3,
    parameter int HOLD_CYC   = 1
) (
    input  logic            clk,
    input  logic            rst,
    fm_bus_master_if.master io_bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (SETUP_CYC > STROBE_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    typedef struct packed {
        logic       rw;
        logic [5:0] addr;
        logic [7:0] data;
    } req_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    // Request FIFO; pointers carry one wrap bit to tell full from empty.
    req_t          r_fifo [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    req_t          w_head;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_cnt_zero;

    logic          r_ceb;
    logic          r_rwb;
    logic [5:0]    r_addr;
    logic [7:0]    r_data;
    logic          r_oe;
    logic          r_rsp_vld;
    logic [7:0]    r_rsp_dat;

    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push     = io_bus.req_valid && !w_full;
    assign w_head     = r_fifo[r_rptr[AW-1:0]];
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wptr[AW-1:0]] <= '{rw: io_bus.req_rw, addr: io_bus.req_addr, data: io_bus.req_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Each state's counter is loaded with its length minus one on entry; leave on zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = CW'(SETUP_CYC - 1);
                end
            end
            S_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_STROBE;
                    w_cnt_nxt   = CW'(STROBE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_STROBE: begin
                if (w_cnt_zero) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = CW'(HOLD_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = S_SETUP;
                        w_cnt_nxt   = CW'(SETUP_CYC - 1);
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are registered off the next-state decision so each phase starts glitch-free
    // on the same edge as the state change. RWb and data_oe always move together, so the
    // initiator never drives data while RWb says read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ceb     <= 1'b1;
            r_rwb     <= 1'b1;
            r_addr    <= '0;
            r_data    <= '0;
            r_oe      <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_dat <= '0;
        end else begin
            r_rsp_vld <= 1'b0;
            if (w_pop) begin
                r_addr <= w_head.addr;
                r_data <= w_head.data;
                r_rwb  <= w_head.rw;
                r_oe   <= ~w_head.rw;
                r_ceb  <= 1'b1;
            end else if (r_state == S_SETUP && w_state_nxt == S_STROBE) begin
                r_ceb <= 1'b0;
            end else if (r_state == S_STROBE && w_state_nxt == S_HOLD) begin
                r_ceb <= 1'b1;
                // Responder data has been stable since its registered CEb fell.
                if (r_rwb) begin
                    r_rsp_vld <= 1'b1;
                    r_rsp_dat <= io_bus.data_in;
                end
            end else if (r_state != S_IDLE && w_state_nxt == S_IDLE) begin
                r_ceb <= 1'b1;
                r_rwb <= 1'b1;
                r_oe  <= 1'b0;
            end
        end
    end

    assign io_bus.req_ready = !w_full;
    assign io_bus.busy      = !w_empty || (r_state != S_IDLE);
    assign io_bus.rsp_valid = r_rsp_vld;
    assign io_bus.rsp_data  = r_rsp_dat;
    assign io_bus.CEb_out   = r_ceb;
    assign io_bus.RWb_out   = r_rwb;
    assign io_bus.addr_out  = r_addr;
    assign io_bus.data_out  = r_data;
    assign io_bus.data_oe   = r_oe;
endmodule

// File: tb/tb_fm_bus_master.sv
// Bench for fm_bus_master: default timing instance (1/3/1) plus a 2/2/2 instance, each with a
// behavioural responder that commits a write once it has seen CEb low on two consecutive edges.
// Read responses are checked against a scoreboard queue filled from a shadow register map.
module tb_fm_bus_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fm_bus_master_if u_if0 ();
    fm_bus_master_if u_if1 ();

    fm_bus_master #(.DEPTH(4), .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1)) u_dut0 (
        .clk(clk), .rst(rst), .io_bus(u_if0));
    fm_bus_master #(.DEPTH(4), .SETUP_CYC(2), .STROBE_CYC(2), .HOLD_CYC(2)) u_dut1 (
        .clk(clk), .rst(rst), .io_bus(u_if1));

    // Responders.
    logic [7:0] mem0 [64];
    logic [7:0] mem1 [64];
    logic [7:0] shadow0 [64];
    logic [7:0] shadow1 [64];
    logic ceb0_q = 1'b1, armed0 = 1'b1, ceb1_q = 1'b1, armed1 = 1'b1;

    always @(posedge clk) begin
        ceb0_q <= u_if0.CEb_out;
        if (u_if0.CEb_out) armed0 <= 1'b1;
        else if (!ceb0_q && armed0) begin
            armed0 <= 1'b0;
            if (!u_if0.RWb_out) mem0[u_if0.addr_out] <= u_if0.data_out;
        end
    end
    always @(posedge clk) begin
        ceb1_q <= u_if1.CEb_out;
        if (u_if1.CEb_out) armed1 <= 1'b1;
        else if (!ceb1_q && armed1) begin
            armed1 <= 1'b0;
            if (!u_if1.RWb_out) mem1[u_if1.addr_out] <= u_if1.data_out;
        end
    end
    assign u_if0.data_in = (!u_if0.CEb_out && u_if0.RWb_out) ? mem0[u_if0.addr_out] : 8'h00;
    assign u_if1.data_in = (!u_if1.CEb_out && u_if1.RWb_out) ? mem1[u_if1.addr_out] : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and bus monitors.
    logic [7:0]  exp_q0 [$];
    logic [7:0]  exp_q1 [$];
    int          starts0 [$];
    int          lens0 [$];
    int          starts1 [$];
    int          lens1 [$];
    int          low0 = 0, low1 = 0, st_tmp0 = 0, st_tmp1 = 0;
    int          stab_err0 = 0, stab_err1 = 0, cont0 = 0, cont1 = 0;
    int          rsp_n0 = 0, rsp_cyc0 = 0;
    logic [14:0] snap0, snap1;
    logic [7:0]  e;

    always @(negedge clk) begin
        if (u_if0.data_oe && u_if0.RWb_out) cont0++;
        if (u_if1.data_oe && u_if1.RWb_out) cont1++;
        if (u_if0.rsp_valid) begin
            rsp_n0++;
            rsp_cyc0 = cyc;
            if (exp_q0.size() == 0) check("rsp0_unexpected", 32'(u_if0.rsp_valid), 0);
            else begin
                e = exp_q0.pop_front();
                check("rsp0_data", 32'(u_if0.rsp_data), 32'(e));
            end
        end
        if (u_if1.rsp_valid) begin
            if (exp_q1.size() == 0) check("rsp1_unexpected", 32'(u_if1.rsp_valid), 0);
            else begin
                e = exp_q1.pop_front();
                check("rsp1_data", 32'(u_if1.rsp_data), 32'(e));
            end
        end
        if (!u_if0.CEb_out) begin
            if (low0 == 0) begin
                st_tmp0 = cyc;
                snap0 = {u_if0.RWb_out, u_if0.addr_out, u_if0.data_out};
            end else if (snap0 != {u_if0.RWb_out, u_if0.addr_out, u_if0.data_out}) stab_err0++;
            low0++;
        end else if (low0 != 0) begin
            starts0.push_back(st_tmp0);
            lens0.push_back(low0);
            low0 = 0;
        end
        if (!u_if1.CEb_out) begin
            if (low1 == 0) begin
                st_tmp1 = cyc;
                snap1 = {u_if1.RWb_out, u_if1.addr_out, u_if1.data_out};
            end else if (snap1 != {u_if1.RWb_out, u_if1.addr_out, u_if1.data_out}) stab_err1++;
            low1++;
        end else if (low1 != 0) begin
            starts1.push_back(st_tmp1);
            lens1.push_back(low1);
            low1 = 0;
        end
    end

    // Drive one request and hold it until accepted; acc is the cycle count of the accepting edge.
    task automatic push(input int k, input logic rw, input logic [5:0] a, input logic [7:0] d,
                        output int acc);
        int   n = 0;
        logic rdy;
        @(negedge clk);
        if (k == 0) begin
            u_if0.req_valid = 1'b1; u_if0.req_rw = rw; u_if0.req_addr = a; u_if0.req_data = d;
        end else begin
            u_if1.req_valid = 1'b1; u_if1.req_rw = rw; u_if1.req_addr = a; u_if1.req_data = d;
        end
        rdy = (k == 0) ? u_if0.req_ready : u_if1.req_ready;
        while (!rdy && n < 100) begin
            @(negedge clk);
            n++;
            rdy = (k == 0) ? u_if0.req_ready : u_if1.req_ready;
        end
        check("push_ready", 32'(rdy), 1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (k == 0) begin
            u_if0.req_valid = 1'b0;
            if (rw) exp_q0.push_back(shadow0[a]); else shadow0[a] = d;
        end else begin
            u_if1.req_valid = 1'b0;
            if (rw) exp_q1.push_back(shadow1[a]); else shadow1[a] = d;
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        @(negedge clk);
        while (((k == 0) ? u_if0.busy : u_if1.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 32'((k == 0) ? u_if0.busy : u_if1.busy), 0);
    endtask

    initial begin
        int acc;
        int rn;
        int lowc;
        int n;
        for (int i = 0; i < 64; i++) begin
            mem0[i] = 8'h00; mem1[i] = 8'h00; shadow0[i] = 8'h00; shadow1[i] = 8'h00;
        end
        u_if0.req_valid = 1'b0; u_if0.req_rw = 1'b0; u_if0.req_addr = '0; u_if0.req_data = '0;
        u_if1.req_valid = 1'b0; u_if1.req_rw = 1'b0; u_if1.req_addr = '0; u_if1.req_data = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ceb",       32'(u_if0.CEb_out), 1);
        check("rst_rwb",       32'(u_if0.RWb_out), 1);
        check("rst_addr",      32'(u_if0.addr_out), 0);
        check("rst_data",      32'(u_if0.data_out), 0);
        check("rst_oe",        32'(u_if0.data_oe), 0);
        check("rst_rsp_valid", 32'(u_if0.rsp_valid), 0);
        check("rst_rsp_data",  32'(u_if0.rsp_data), 0);
        check("rst_busy",      32'(u_if0.busy), 0);
        check("rst_ready",     32'(u_if0.req_ready), 1);
        check("rst_ready1",    32'(u_if1.req_ready), 1);
        rst = 1'b0;

        // Single write 0x15 <- 0x80, phase by phase.
        push(0, 1'b0, 6'h15, 8'h80, acc);
        @(negedge clk);
        check("w1_idle_busy", 32'(u_if0.busy), 1);
        check("w1_idle_ceb",  32'(u_if0.CEb_out), 1);
        @(negedge clk);
        check("w1_setup_ceb",  32'(u_if0.CEb_out), 1);
        check("w1_setup_rwb",  32'(u_if0.RWb_out), 0);
        check("w1_setup_addr", 32'(u_if0.addr_out), 32'h15);
        check("w1_setup_data", 32'(u_if0.data_out), 32'h80);
        check("w1_setup_oe",   32'(u_if0.data_oe), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w1_strobe_ceb", 32'(u_if0.CEb_out), 0);
        end
        @(negedge clk);
        check("w1_hold_ceb",  32'(u_if0.CEb_out), 1);
        check("w1_hold_rwb",  32'(u_if0.RWb_out), 0);
        check("w1_hold_addr", 32'(u_if0.addr_out), 32'h15);
        check("w1_hold_data", 32'(u_if0.data_out), 32'h80);
        @(negedge clk);
        check("w1_idle_busy0", 32'(u_if0.busy), 0);
        check("w1_idle_rwb",   32'(u_if0.RWb_out), 1);
        check("w1_idle_oe",    32'(u_if0.data_oe), 0);
        check("w1_idle_addr",  32'(u_if0.addr_out), 32'h15);
        check("w1_strobe_len",   32'(lens0[0]), 3);
        check("w1_strobe_start", 32'(starts0[0]), 32'(acc + 2));
        check("w1_mem",          32'(mem0[6'h15]), 32'h80);
        starts0.delete(); lens0.delete();

        // Write 0x18 <- 0x35, then a lone read of 0x18.
        push(0, 1'b0, 6'h18, 8'h35, acc);
        wait_idle(0);
        push(0, 1'b1, 6'h18, 8'h00, acc);
        wait_idle(0);
        check("r1_rsp_cycle", 32'(rsp_cyc0), 32'(acc + 5));
        @(negedge clk);
        check("r1_rsp_hold",  32'(u_if0.rsp_data), 32'h35);
        check("r1_contention", 32'(cont0), 0);
        check("r1_q_empty",   32'(exp_q0.size()), 0);
        starts0.delete(); lens0.delete();

        // A lead read keeps the FSM busy while four writes fill the FIFO.
        push(0, 1'b1, 6'h15, 8'h00, acc);
        for (int i = 0; i < 4; i++) push(0, 1'b0, 6'(i), 8'(8'h11 * (i + 1)), acc);
        @(negedge clk);
        check("fill_ready_low", 32'(u_if0.req_ready), 0);
        wait_idle(0);
        check("fill_strobes", 32'(starts0.size()), 5);
        for (int i = 0; i < 5 && i < starts0.size(); i++) begin
            check("fill_len", 32'(lens0[i]), 3);
            if (i > 0) check("fill_spacing", 32'(starts0[i] - starts0[i-1]), 5);
        end
        check("fill_rsp_held", 32'(u_if0.rsp_data), 32'h80);
        for (int i = 0; i < 4; i++) push(0, 1'b1, 6'(i), 8'h00, acc);
        wait_idle(0);
        check("fill_q_empty", 32'(exp_q0.size()), 0);
        for (int i = 0; i < 4; i++) check("fill_mem", 32'(mem0[i]), 32'(8'h11 * (i + 1)));
        starts0.delete(); lens0.delete();

        // Interleaved write then read of 0x25 in consecutive cycles.
        push(0, 1'b0, 6'h25, 8'hA5, acc);
        push(0, 1'b1, 6'h25, 8'h00, acc);
        wait_idle(0);
        check("il_q_empty",  32'(exp_q0.size()), 0);
        check("il_rsp_data", 32'(u_if0.rsp_data), 32'hA5);
        check("il_stable",   32'(stab_err0), 0);
        check("il_contention", 32'(cont0), 0);
        starts0.delete(); lens0.delete();

        // Reset during the first strobe cycle of a write with two more queued.
        push(0, 1'b0, 6'h30, 8'h77, acc);
        push(0, 1'b0, 6'h31, 8'h11, acc);
        push(0, 1'b0, 6'h32, 8'h22, acc);
        n = 0;
        while (u_if0.CEb_out && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mr_strobe_seen", 32'(u_if0.CEb_out), 0);
        rn = rsp_n0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mr_ceb",      32'(u_if0.CEb_out), 1);
        check("mr_oe",       32'(u_if0.data_oe), 0);
        check("mr_busy",     32'(u_if0.busy), 0);
        check("mr_ready",    32'(u_if0.req_ready), 1);
        check("mr_rsp_data", 32'(u_if0.rsp_data), 0);
        lowc = 0;
        repeat (12) begin
            @(negedge clk);
            if (!u_if0.CEb_out) lowc++;
        end
        check("mr_no_strobe", 32'(lowc), 0);
        check("mr_no_rsp",    32'(rsp_n0), 32'(rn));
        check("mr_mem30",     32'(mem0[6'h30]), 0);
        check("mr_mem31",     32'(mem0[6'h31]), 0);
        shadow0[6'h30] = 8'h00; shadow0[6'h31] = 8'h00; shadow0[6'h32] = 8'h00;
        push(0, 1'b1, 6'h30, 8'h00, acc);
        wait_idle(0);
        check("mr_q_empty", 32'(exp_q0.size()), 0);

        // 2/2/2 timing instance: write then read-back of 0x1D.
        push(1, 1'b0, 6'h1D, 8'h5A, acc);
        push(1, 1'b1, 6'h1D, 8'h00, rn);
        wait_idle(1);
        check("sw_strobes", 32'(starts1.size()), 2);
        if (starts1.size() == 2) begin
            check("sw_start",   32'(starts1[0]), 32'(acc + 3));
            check("sw_len0",    32'(lens1[0]), 2);
            check("sw_len1",    32'(lens1[1]), 2);
            check("sw_spacing", 32'(starts1[1] - starts1[0]), 6);
        end
        check("sw_q_empty",  32'(exp_q1.size()), 0);
        check("sw_rsp_data", 32'(u_if1.rsp_data), 32'h5A);
        check("sw_mem",      32'(mem1[6'h1D]), 32'h5A);
        check("sw_stable",   32'(stab_err1), 0);
        check("sw_contention", 32'(cont1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
